delay_cal_ctrl: RTL and testbench
=================================

# delay_cal_ctrl

Synchronous calibration controller for the click-style matched-delay chains (a selectable number of two-unit delay stages). It picks a tap setting, launches a two-phase transition into the chain, times the return against the system clock, and steps the tap until the measured delay meets a programmed target. It sits between the clocked configuration domain and the asynchronous delay fabric; its tap output drives the chain's stage-select mux.

## Interface
- TAP_W, 3: tap select width; tap n selects n+1 two-unit stages (0..2^TAP_W-1).
- CNT_W, 8: width of target, measurement and timeout counters.
- SYNC_STAGES, 2: synchronizer depth on the return path.
- SETTLE_CYC, 4: consecutive quiet cycles required before each launch.
- TIMEOUT, 255: max cycles in SETTLE or WAIT before error (≤ 2^CNT_W-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cal_start  in  1  start pulse; sampled only in IDLE.
- target_cyc  in  CNT_W  required minimum delay in clk cycles; captured at start.
- tap_sel  out  TAP_W  stage select to delay chain.
- launch_o  out  1  two-phase request into chain input (level toggles per launch).
- ret_i  in  1  chain output, asynchronous to clk.
- meas_cyc  out  CNT_W  last measured round-trip in cycles.
- cal_busy  out  1  high from cycle after accepted start until DONE.
- cal_done  out  1  one-cycle pulse at end of calibration.
- cal_err  out  1  sticky until next accepted start; failure flag.

## Operation
- Reset values: tap_sel=0, launch_o=0, meas_cyc=0, cal_busy=0, cal_done=0, cal_err=0, state IDLE, counters 0.
- ret_i passes through SYNC_STAGES flops -> ret_s; only ret_s is used.
- States: IDLE, SETTLE, LAUNCH, WAIT, EVAL, DONE.
- IDLE: on cal_start, capture target_cyc, tap_sel<=0, cal_err<=0, cal_busy<=1, -> SETTLE.
- SETTLE: quiet counter increments while ret_s==launch_o, clears on mismatch; reaching SETTLE_CYC -> LAUNCH. Timeout counter reaching TIMEOUT -> cal_err<=1, DONE.
- LAUNCH: launch_o<=~launch_o, cycle counter<=0, -> WAIT.
- WAIT: counter increments each cycle; first cycle with ret_s==launch_o -> meas_cyc<=counter+1, -> EVAL. Counter reaching TIMEOUT -> meas_cyc<=TIMEOUT, cal_err<=1, DONE.
- EVAL: meas_cyc>=target -> DONE (success, tap held). Else tap_sel==max -> cal_err<=1, DONE. Else tap_sel<=tap_sel+1, -> SETTLE.
- DONE: cal_done=1 one cycle, cal_busy<=0, -> IDLE. tap_sel and meas_cyc hold until next start.
- Comparisons unsigned; counters saturate, never wrap.
- cal_start while busy: ignored, no queuing. target_cyc changes while busy: ignored.
- rst mid-operation: all outputs to reset values next edge, including launch_o=0 (chain may transition; next SETTLE absorbs it).

## Timing
- cal_start at edge t -> cal_busy=1 after edge t+1.
- meas_cyc = cycles from launch_o toggle edge to first edge with ret_s matching = chain delay (rounded up to cycles) + SYNC_STAGES.
- Per tap iteration: ≥ SETTLE_CYC + 1 (LAUNCH) + meas + 1 (EVAL) cycles.
- cal_done and cal_busy falling occur on the same edge; cal_err/tap_sel/meas_cyc valid at that edge.

## Structure
- Package delay_cal_pkg: state enum, default widths, TAP_MAX constant.
- Sub-module sync_ff (SYNC_STAGES-deep flop chain, reset to 0) for ret_i.
- FSM, counters and tap register in delay_cal_ctrl.

## Test plan
- Bench chain model ret_i follows launch_o after tap+1 cycles, SYNC_STAGES=2, target=5 -> meas 3,4,5; done with tap_sel=2, meas_cyc=5, cal_err=0.
- Same model, target=20 -> tap 7 reached with meas_cyc=10, cal_done with cal_err=1, tap_sel=7.
- ret_i stuck at 0 after first launch -> WAIT times out, meas_cyc=255, cal_err=1, cal_done pulse.
- target=0 -> success at tap_sel=0, one iteration, meas_cyc=3.
- cal_start pulsed during WAIT -> ignored; exactly one cal_done per accepted start.
- rst asserted in WAIT -> next edge all outputs at reset values; subsequent start calibrates normally (target=5 -> tap_sel=2).

Source files
------------

// File: rtl/delay_cal_pkg.sv
// Shared types and default sizing for the matched-delay calibration controller.
package delay_cal_pkg;

   localparam int unsigned TAP_W_DEF       = 3;
   localparam int unsigned CNT_W_DEF       = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned SETTLE_CYC_DEF  = 4;
   localparam int unsigned TIMEOUT_DEF     = 255;
   localparam int unsigned TAP_MAX         = (1 << TAP_W_DEF) - 1;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StLaunch,
      StWait,
      StEval,
      StDone
   } calState_e;

endpackage

// File: rtl/sync_ff.sv
// Reset-to-zero flop chain bringing the asynchronous chain return into the clk domain.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/delay_cal_ctrl.sv
// Steps the delay-chain tap until a two-phase launch takes at least target_cyc clocks
// to come back; flags an error on timeout or when the longest tap is still too fast.
module delay_cal_ctrl
   import delay_cal_pkg::*;
#(
   parameter int unsigned TAP_W       = TAP_W_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cal_start,
   input  logic [CNT_W-1:0] target_cyc,
   output logic [TAP_W-1:0] tap_sel,
   output logic             launch_o,
   input  logic             ret_i,
   output logic [CNT_W-1:0] meas_cyc,
   output logic             cal_busy,
   output logic             cal_done,
   output logic             cal_err
);

   localparam logic [TAP_W-1:0] TapMax     = '1;
   localparam logic [CNT_W-1:0] SettleCnt  = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

   calState_e        state;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] quietCnt;
   logic [CNT_W-1:0] toCnt;
   logic [CNT_W-1:0] cycCnt;
   logic             retS;
   logic             retMatch;
   logic [CNT_W-1:0] quietNext;
   logic [CNT_W-1:0] toNext;
   logic [CNT_W-1:0] cycNext;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_retSync (
      .clk(clk),
      .rst(rst),
      .d  (ret_i),
      .q  (retS)
   );

   // Chain output has caught up with the request when both phases agree.
   assign retMatch  = (retS == launch_o);
   assign quietNext = !retMatch ? '0 : ((quietCnt == '1) ? quietCnt : quietCnt + 1'b1);
   assign toNext    = (toCnt == '1) ? toCnt : toCnt + 1'b1;
   assign cycNext   = (cycCnt == '1) ? cycCnt : cycCnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         tap_sel  <= '0;
         launch_o <= 1'b0;
         meas_cyc <= '0;
         cal_busy <= 1'b0;
         cal_done <= 1'b0;
         cal_err  <= 1'b0;
         target   <= '0;
         quietCnt <= '0;
         toCnt    <= '0;
         cycCnt   <= '0;
      end else begin
         cal_done <= 1'b0;
         case (state)
            StIdle: begin
               if (cal_start) begin
                  target   <= target_cyc;
                  tap_sel  <= '0;
                  cal_err  <= 1'b0;
                  cal_busy <= 1'b1;
                  quietCnt <= '0;
                  toCnt    <= '0;
                  state    <= StSettle;
               end
            end
            StSettle: begin
               quietCnt <= quietNext;
               toCnt    <= toNext;
               if (quietNext >= SettleCnt) begin
                  state <= StLaunch;
               end else if (toNext >= TimeoutCnt) begin
                  cal_err <= 1'b1;
                  state   <= StDone;
               end
            end
            StLaunch: begin
               launch_o <= ~launch_o;
               cycCnt   <= '0;
               state    <= StWait;
            end
            StWait: begin
               if (retMatch) begin
                  meas_cyc <= cycNext;
                  state    <= StEval;
               end else if (cycNext >= TimeoutCnt) begin
                  meas_cyc <= TimeoutCnt;
                  cal_err  <= 1'b1;
                  state    <= StDone;
               end else begin
                  cycCnt <= cycNext;
               end
            end
            StEval: begin
               if (meas_cyc >= target) begin
                  state <= StDone;
               end else if (tap_sel == TapMax) begin
                  cal_err <= 1'b1;
                  state   <= StDone;
               end else begin
                  tap_sel  <= tap_sel + 1'b1;
                  quietCnt <= '0;
                  toCnt    <= '0;
                  state    <= StSettle;
               end
            end
            StDone: begin
               cal_done <= 1'b1;
               cal_busy <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Randomized scoreboard bench: a chain model returns launch_o after tap+1 cycles and a
// plain-arithmetic reference predicts the final tap, measurement and error flag.
module tb_delay_cal_ctrl;
   import delay_cal_pkg::*;

   localparam int SYNC = 2;
   localparam int TMO  = 255;

   typedef struct {
      int tap;
      int meas;
      int err;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cal_start = 1'b0;
   logic [7:0] target_cyc = '0;
   logic [2:0] tap_sel;
   logic       launch_o;
   logic       ret_i;
   logic [7:0] meas_cyc;
   logic       cal_busy;
   logic       cal_done;
   logic       cal_err;

   int   nCmp = 0;
   int   nFail = 0;
   int   doneCnt = 0;
   int   expDone = 0;
   bit   stuck = 1'b0;
   res_t sbQ[$];
   res_t monE;

   // Chain model: tap n delays the request by n+1 clock samples.
   logic [6:0] hist = '0;
   logic [7:0] chainTaps;
   always @(posedge clk) hist <= {hist[5:0], launch_o};
   assign chainTaps = {hist, launch_o};
   assign ret_i     = stuck ? 1'b0 : chainTaps[tap_sel];

   always #5 clk = ~clk;

   delay_cal_ctrl #(
      .TAP_W      (3),
      .CNT_W      (8),
      .SYNC_STAGES(SYNC),
      .SETTLE_CYC (4),
      .TIMEOUT    (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cal_start (cal_start),
      .target_cyc(target_cyc),
      .tap_sel   (tap_sel),
      .launch_o  (launch_o),
      .ret_i     (ret_i),
      .meas_cyc  (meas_cyc),
      .cal_busy  (cal_busy),
      .cal_done  (cal_done),
      .cal_err   (cal_err)
   );

   task automatic check(input string name, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: try taps in order, each returning in (tap+1)+SYNC cycles.
   function automatic res_t refModel(input int tgt, input bit stuckRet);
      res_t r;
      r.tap = 0; r.meas = TMO; r.err = 1;
      if (stuckRet) return r;
      for (int t = 0; t <= int'(TAP_MAX); t++) begin
         r.tap  = t;
         r.meas = t + 1 + SYNC;
         if (r.meas >= tgt) begin
            r.err = 0;
            return r;
         end
      end
      return r;
   endfunction

   task automatic checkResetOutputs(input string tag);
      check({tag, "_tap_sel"}, int'(tap_sel), 0);
      check({tag, "_launch_o"}, int'(launch_o), 0);
      check({tag, "_meas_cyc"}, int'(meas_cyc), 0);
      check({tag, "_cal_busy"}, int'(cal_busy), 0);
      check({tag, "_cal_done"}, int'(cal_done), 0);
      check({tag, "_cal_err"}, int'(cal_err), 0);
   endtask

   task automatic waitLaunch();
      logic l0 = launch_o;
      int   i = 0;
      while (launch_o == l0 && i < 400) begin
         @(negedge clk);
         i++;
      end
      check("launch_seen", int'(launch_o != l0), 1);
   endtask

   task automatic runCal(input int tgt, input bit poke);
      bit got = 1'b0;
      sbQ.push_back(refModel(tgt, stuck));
      expDone++;
      @(negedge clk);
      target_cyc = 8'(tgt);
      cal_start  = 1'b1;
      @(negedge clk);
      cal_start  = 1'b0;
      target_cyc = 8'($urandom);
      check("busy_after_start", int'(cal_busy), 1);
      if (poke) begin
         waitLaunch();
         cal_start = 1'b1;
         @(negedge clk);
         cal_start = 1'b0;
      end
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (cal_done) got = 1'b1;
      end
      check("done_within_budget", int'(got), 1);
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && cal_done) begin
         doneCnt++;
         if (sbQ.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            monE = sbQ.pop_front();
            check("tap_sel", int'(tap_sel), monE.tap);
            check("meas_cyc", int'(meas_cyc), monE.meas);
            check("cal_err", int'(cal_err), monE.err);
            check("busy_low_at_done", int'(cal_busy), 0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge clk);

      runCal(5, 1'b0);
      runCal(20, 1'b0);
      runCal(0, 1'b0);
      runCal(5, 1'b1);
      for (int k = 0; k < 6; k++) begin
         runCal(int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
      end

      // Reset while waiting for the return: the aborted run must not complete.
      @(negedge clk);
      target_cyc = 8'd5;
      cal_start  = 1'b1;
      @(negedge clk);
      cal_start  = 1'b0;
      waitLaunch();
      rst = 1'b1;
      @(negedge clk);
      checkResetOutputs("mid_reset");
      rst = 1'b0;
      runCal(5, 1'b0);

      // Return path dead after the first launch from a clean reset.
      pulseReset();
      stuck = 1'b1;
      runCal(9, 1'b0);
      stuck = 1'b0;
      repeat (4) @(negedge clk);

      check("queue_drained", sbQ.size(), 0);
      check("done_count", doneCnt, expDone);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
